majority_ballot_collector: RTL and testbench
============================================

Name: majority_ballot_collector

Overview:
- Upstream stage for the 4-input majority block. Collects one ballot from each of four voters (vote switch plus cast push-button), debounces the buttons, and locks each voter's first cast.
- Presents the finished ballot on A, B, C and D with a valid flag.
- A round closes when all four voters have cast, or when a timeout expires.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles needed before a debounced button level changes. Range 1 to 255.
- TIMEOUT, 1000: cycles allowed in COLLECT before the round force-closes. Range 2 to 2^20-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  synchronous pulse; opens a voting round (honoured in IDLE only).
- clear  in  1  synchronous pulse; ends the round and returns to IDLE.
- sw  in  4  raw vote switches; bit i is voter i's choice (1 = yes).
- cast  in  4  raw, bouncy cast buttons; bit i belongs to voter i.
- A  out  1  voter 0 ballot bit.
- B  out  1  voter 1 ballot bit.
- C  out  1  voter 2 ballot bit.
- D  out  1  voter 3 ballot bit.
- ballot_valid  out  1  high while A to D hold a closed ballot.
- cast_mask  out  4  bit i set once voter i's vote is recorded this round.
- timed_out  out  1  high in CLOSED if the round ended by timeout.
- busy  out  1  high in COLLECT.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All of the following clear to 0: A to D, ballot_valid, cast_mask, timed_out, busy, vote registers, timer, synchronisers, debounce counters, debounced levels.
- Input conditioning: sw and cast each pass through 2-FF synchronisers.
- Debounce, per cast channel:
  - A counter increments while the synced level differs from the debounced level, and resets to 0 when they match.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A cast event is a one-cycle pulse on the debounced 0-to-1 transition.
  - Release also debounces, so one press produces exactly one event.
- FSM states: IDLE, COLLECT, CLOSED.
- IDLE:
  - busy=0, ballot_valid=0, A to D=0.
  - start (with clear low) moves to COLLECT next cycle and zeroes cast_mask, the vote registers, timer and timed_out.
- COLLECT:
  - busy=1.
  - Timer increments every cycle.
  - For each channel i with a cast event and cast_mask[i]=0: vote[i] takes synced sw[i] and cast_mask[i] is set, on the same edge.
  - Events on already-cast channels are ignored; a voter cannot change a recorded vote.
  - Several channels may record in the same cycle.
  - If the mask including this cycle's updates equals 4'hF, go to CLOSED next cycle with timed_out=0.
  - Otherwise, if timer equals TIMEOUT-1, go to CLOSED with timed_out=1.
  - If the final cast lands in the timeout cycle, the cast is recorded and timed_out=0.
- CLOSED:
  - ballot_valid=1, busy=0.
  - A=vote[0], B=vote[1], C=vote[2], D=vote[3]. Uncast voters read 0.
  - Further casts are ignored.
  - State holds until clear.
- clear: in COLLECT or CLOSED, go to IDLE next cycle. ballot_valid and busy drop that cycle; cast_mask and timed_out stay readable until the next start.
- Priority and ignore rules:
  - clear has priority over start.
  - start outside IDLE is ignored.
  - Button activity in IDLE updates the debouncers but records nothing.
- Output timing: all outputs are registered. A to D change only on entry to or exit from CLOSED, so the downstream combinational majority output Y is stable whenever ballot_valid=1.
- Latency from a stable raw press to cast_mask set: 2 synchroniser cycles + DEB_CYCLES + 1 recording edge.

Test Plan (DEB_CYCLES=4, TIMEOUT=100):
- Reset check: assert rst mid-COLLECT with cast_mask=4'b0011 -> every output reads 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and busy=0.
- Full ballot: start; sw=4'b1011; press cast[0], cast[1], cast[3], cast[2] cleanly, 20 cycles apart -> cast_mask steps to 4'hF; next cycle ballot_valid=1, {D,C,B,A}=4'b1011, timed_out=0, and downstream Y=1.
- Bounce and lock:
  - Toggle cast[1] with 2-cycle glitches (shorter than DEB_CYCLES) -> nothing is recorded.
  - A clean press with sw[1]=1 -> cast_mask[1] is set exactly 7 cycles after the raw edge.
  - Flip sw[1] to 0 and press again -> vote[1] stays 1.
- Timeout: start; only voters 0 and 2 cast yes -> at timer 99 the block enters CLOSED with timed_out=1, {D,C,B,A}=4'b0101 and cast_mask=4'b0101.
- Simultaneous events:
  - The last two voters' events land in the same cycle as timer=99 -> both are recorded and timed_out=0.
  - Pulse start and clear together while in CLOSED -> FSM returns to IDLE and stays there.
- Ignore rules: start pulsed during COLLECT -> timer and mask are unchanged; cast presses in CLOSED -> cast_mask and A to D are unchanged.

Source files
------------

// File: rtl/majority_ballot_collector.sv
// Four-voter ballot collector: synchronises and debounces cast buttons, locks each
// voter's first cast, and presents a registered ballot once the round closes.
module majority_ballot_collector #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic [3:0] sw,
    input  logic [3:0] cast,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       ballot_valid,
    output logic [3:0] cast_mask,
    output logic       timed_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CLOSED
    } state_t;

    localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT - 1);

    logic [3:0]  sw_s1, sw_s2;
    logic [3:0]  cast_s1, cast_s2;
    logic [7:0]  deb_cnt [4];
    logic [3:0]  deb_lvl;
    logic [3:0]  cast_evt;

    state_t      state, state_next;
    logic [3:0]  vote, vote_next;
    logic [3:0]  mask_next;
    logic [3:0]  new_cast;
    logic [19:0] timer, timer_next;
    logic        timed_out_next;

    // Two-flop synchronisers for the asynchronous switch and button inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            cast_s1 <= '0;
            cast_s2 <= '0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            cast_s1 <= cast;
            cast_s2 <= cast_s1;
        end
    end

    // Debounce: the level flips after DEB_CYCLES consecutive disagreeing cycles; the
    // event flop pulses on the same edge as a 0-to-1 flip so recording happens one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_lvl  <= '0;
            cast_evt <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cast_evt[i] <= 1'b0;
                if (cast_s2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i]  <= cast_s2[i];
                    deb_cnt[i]  <= '0;
                    cast_evt[i] <= cast_s2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next     = state;
        mask_next      = cast_mask;
        vote_next      = vote;
        timer_next     = timer;
        timed_out_next = timed_out;
        new_cast       = '0;
        unique case (state)
            IDLE: begin
                if (start && !clear) begin
                    state_next     = COLLECT;
                    mask_next      = '0;
                    vote_next      = '0;
                    timer_next     = '0;
                    timed_out_next = 1'b0;
                end
            end
            COLLECT: begin
                if (clear) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 20'd1;
                    new_cast   = cast_evt & ~cast_mask;
                    mask_next  = cast_mask | new_cast;
                    vote_next  = (vote & ~new_cast) | (sw_s2 & new_cast);
                    // A complete ballot wins over a coincident timeout.
                    if (mask_next == 4'hF) begin
                        state_next     = CLOSED;
                        timed_out_next = 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        state_next     = CLOSED;
                        timed_out_next = 1'b1;
                    end
                end
            end
            CLOSED: begin
                if (clear) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state flop.
    // NOTE: the vote register is reset along with everything else so uncast voters read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote         <= '0;
            cast_mask    <= '0;
            timer        <= '0;
            timed_out    <= 1'b0;
            busy         <= 1'b0;
            ballot_valid <= 1'b0;
            {D, C, B, A} <= '0;
        end else begin
            vote         <= vote_next;
            cast_mask    <= mask_next;
            timer        <= timer_next;
            timed_out    <= timed_out_next;
            busy         <= (state_next == COLLECT);
            ballot_valid <= (state_next == CLOSED);
            {D, C, B, A} <= (state_next == CLOSED) ? vote_next : 4'b0000;
        end
    end

endmodule

// File: tb/tb_majority_ballot_collector.sv
// Scoreboard bench for majority_ballot_collector with DEB_CYCLES=4, TIMEOUT=100.
module tb_majority_ballot_collector;

    localparam int unsigned DEB = 4;
    localparam int unsigned TO  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sw = '0;
    logic [3:0] cast = '0;
    logic       A, B, C, D;
    logic       ballot_valid;
    logic [3:0] cast_mask;
    logic       timed_out;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];   // {timed_out, cast_mask, D, C, B, A}
    int waited;
    int n;
    logic y;

    majority_ballot_collector #(.DEB_CYCLES(DEB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .sw(sw), .cast(cast),
        .A(A), .B(B), .C(C), .D(D), .ballot_valid(ballot_valid),
        .cast_mask(cast_mask), .timed_out(timed_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        cast = cast | m;
        tick(hold);
        cast = cast & ~m;
        tick(hold);
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        logic [8:0] e;
        cycles = 0;
        while (!ballot_valid && cycles < budget) begin
            tick(1);
            cycles++;
        end
        check("valid_seen", 32'(ballot_valid), 32'd1);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ballot", 32'({timed_out, cast_mask, D, C, B, A}), 32'(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset, then async reset asserted mid-COLLECT.
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_outs", 32'({A, B, C, D, ballot_valid, cast_mask, timed_out, busy}), 32'd0);
        pulse_start();
        sw   = 4'b0011;
        cast = 4'b0011;
        tick(9);
        check("pre_rst_mask", 32'(cast_mask), 32'h3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_outs", 32'({A, B, C, D, ballot_valid, cast_mask, timed_out, busy}), 32'd0);
        cast = '0;
        tick(2);
        rst = 1'b0;
        tick(8);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(ballot_valid), 32'd0);

        // Full ballot, voters cast in order 0,1,3,2.
        sw = 4'b1011;
        tick(3);
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_mask", 32'(cast_mask), 32'h0);
        exp_q.push_back({1'b0, 4'hF, 4'b1011});
        press(4'b0001, 10);
        check("mask_step0", 32'(cast_mask), 32'h1);
        press(4'b0010, 10);
        check("mask_step1", 32'(cast_mask), 32'h3);
        press(4'b1000, 10);
        check("mask_step3", 32'(cast_mask), 32'hB);
        press(4'b0100, 10);
        wait_valid(20, waited);
        y = ($countones({A, B, C, D}) >= 3);
        check("y_full", 32'(y), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_valid", 32'(ballot_valid), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_abcd", 32'({D, C, B, A}), 32'h0);
        check("clear_mask_kept", 32'(cast_mask), 32'hF);

        // Bounce rejection, latency, vote lock, start ignored in COLLECT.
        sw = 4'b0010;
        tick(3);
        pulse_start();
        exp_q.push_back({1'b0, 4'hF, 4'b0010});
        for (int i = 0; i < 4; i++) begin
            cast[1] = 1'b1;
            tick(2);
            cast[1] = 1'b0;
            tick(2);
        end
        tick(6);
        check("bounce_mask", 32'(cast_mask), 32'h0);
        cast[1] = 1'b1;
        n = 0;
        while (!cast_mask[1] && n < 20) begin
            tick(1);
            n++;
        end
        check("press_latency", 32'(n), 32'd7);
        tick(2);
        cast[1] = 1'b0;
        tick(8);
        sw = 4'b0000;
        tick(3);
        press(4'b0010, 8);
        check("relock_mask", 32'(cast_mask), 32'h2);
        pulse_start();
        check("start_ign_mask", 32'(cast_mask), 32'h2);
        check("start_ign_busy", 32'(busy), 32'd1);
        cast = 4'b1101;
        tick(8);
        wait_valid(10, waited);
        cast = '0;
        tick(8);
        sw = 4'b1111;
        tick(3);
        press(4'b1111, 8);
        check("closed_ign_mask", 32'(cast_mask), 32'hF);
        check("closed_ign_abcd", 32'({D, C, B, A}), 32'h2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);

        // Timeout with only voters 0 and 2.
        sw = 4'b0101;
        tick(3);
        pulse_start();
        exp_q.push_back({1'b1, 4'b0101, 4'b0101});
        press(4'b0101, 10);
        n = 20;
        wait_valid(200, waited);
        check("timeout_cycle", 32'(waited + n), 32'd100);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(2);

        // Last two casts land in the timeout cycle; then start+clear together in CLOSED.
        sw = 4'b1111;
        tick(3);
        pulse_start();
        exp_q.push_back({1'b0, 4'hF, 4'b1111});
        cast = 4'b0011;
        tick(10);
        cast = 4'b0000;
        tick(83);
        check("near_to_mask", 32'(cast_mask), 32'h3);
        cast = 4'b1100;
        wait_valid(20, waited);
        check("last_cast_latency", 32'(waited), 32'd7);
        start = 1'b1;
        clear = 1'b1;
        tick(1);
        start = 1'b0;
        clear = 1'b0;
        tick(3);
        check("sc_busy", 32'(busy), 32'd0);
        check("sc_valid", 32'(ballot_valid), 32'd0);
        check("sc_abcd", 32'({D, C, B, A}), 32'h0);
        cast = '0;
        tick(10);
        check("sc_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
